// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM states and store lane masks for data_mem_unit
package dmem_pkg;
   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_e;
   typedef enum logic {IDLE, LOAD_WAIT} state_e;
   localparam logic [3:0] LANE_B = 4'b0001;
   localparam logic [3:0] LANE_H = 4'b0011;
   localparam logic [3:0] LANE_W = 4'b1111;
endpackage

// File: rtl/dmem_load_format.sv
// dmem_load_format: selects byte/half/word from a raw word and sign- or zero-extends it
module dmem_load_format (
   input  logic [31:0] raw,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);
   logic [31:0] shifted;
   logic [15:0] half;
   always_comb begin
      shifted = raw >> {off, 3'b000};
      half = off[1] ? raw[31:16] : raw[15:0];
      data = funct3[1] ? raw :
             funct3[0] ? {{16{!funct3[2] && half[15]}}, half} :
                         {{24{!funct3[2] && shifted[7]}}, shifted[7:0]};
   end
endmodule

// File: rtl/data_mem_unit.sv
// data_mem_unit: 512-byte data memory stage; DMEM_LOAD_BYPASS_EN makes loads combinational
module data_mem_unit
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 9,
   parameter int DEPTH_WORDS = 128
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [2:0]            funct3,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  stall,
   output logic                  err
);
   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
   logic [ADDR_WIDTH-3:0] idx;
   logic [DATA_WIDTH-1:0] wdata, fmt_data;
   logic [3:0] we;
   logic aligned, st_ok, ld_ok, bad;
   state_e state, next;

   assign idx = addr[ADDR_WIDTH-1:2];

   always_comb begin
      aligned = funct3[1] ? addr[1:0] == 2'b00 : funct3[0] ? !addr[0] : 1'b1;
      st_ok = state == IDLE && mem_write && funct3 inside {F3_B, F3_H, F3_W} && aligned;
      ld_ok = state == IDLE && !mem_write && mem_read &&
              funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU} && aligned;
      bad = state == IDLE && (mem_write || mem_read) && !st_ok && !ld_ok;
      we = !st_ok ? 4'b0000 : (funct3[1] ? LANE_W : funct3[0] ? LANE_H : LANE_B) << addr[1:0];
      wdata = funct3[1] ? wr_data : funct3[0] ? {2{wr_data[15:0]}} : {4{wr_data[7:0]}};
`ifdef DMEM_LOAD_BYPASS_EN
      next = IDLE;
      stall = 1'b0;
`else
      next = ld_ok ? LOAD_WAIT : IDLE;
      stall = ld_ok;
`endif
   end

   always_ff @(posedge clk) begin
      state <= rst ? IDLE : next;
      err <= !rst && bad;
   end

   // RAM is deliberately left out of reset
   always_ff @(posedge clk)
      for (int i = 0; i < 4; i++)
         if (we[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];

`ifdef DMEM_LOAD_BYPASS_EN
   dmem_load_format u_fmt (.raw(mem[idx]), .off(addr[1:0]), .funct3(funct3), .data(fmt_data));
   assign rd_data = fmt_data;
   assign rd_valid = ld_ok;
`else
   logic [DATA_WIDTH-1:0] raw_q;
   logic [1:0] off_q;
   logic [2:0] f3_q;

   always_ff @(posedge clk)
      if (ld_ok) begin
         raw_q <= mem[idx];
         off_q <= addr[1:0];
         f3_q <= funct3;
      end

   dmem_load_format u_fmt (.raw(raw_q), .off(off_q), .funct3(f3_q), .data(fmt_data));

   always_ff @(posedge clk) begin
      rd_valid <= !rst && state == LOAD_WAIT;
      if (rst) rd_data <= '0;
      else if (state == LOAD_WAIT) rd_data <= fmt_data;
   end
`endif
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: scoreboard bench for data_mem_unit (registered-load build)
module tb_data_mem_unit;
   logic clk = 1'b0;
   logic rst, mem_read, mem_write, rd_valid, stall, err;
   logic [8:0] addr;
   logic [2:0] funct3;
   logic [31:0] wr_data, rd_data, last_rd;

   typedef struct {
      bit          is_err;
      logic [31:0] data;
   } exp_t;
   exp_t q[$];
   exp_t m_e;
   int n_cmp = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   data_mem_unit dut (
      .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
      .addr(addr), .funct3(funct3), .wr_data(wr_data),
      .rd_data(rd_data), .rd_valid(rd_valid), .stall(stall), .err(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: every rd_valid/err pulse must match the oldest expected response
   always @(negedge clk)
      if (rd_valid === 1'b1 || err === 1'b1) begin
         if (q.size() == 0) chk("unexpected_output", {30'd0, rd_valid, err}, 32'd0);
         else begin
            m_e = q.pop_front();
            chk(m_e.is_err ? "err_pulse" : "rd_valid_pulse", {30'd0, rd_valid, err},
                m_e.is_err ? 32'd1 : 32'd2);
            if (!m_e.is_err) chk("rd_data", rd_data, m_e.data);
         end
      end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic store(input logic [2:0] f, input logic [8:0] a, input logic [31:0] d,
                        input logic also_rd);
      mem_write = 1'b1; mem_read = also_rd; funct3 = f; addr = a; wr_data = d;
      @(negedge clk);
      chk("store_stall", {31'd0, stall}, 32'd0);
      step();
      mem_write = 1'b0; mem_read = 1'b0;
   endtask

   // request stays asserted through LOAD_WAIT; it must not be re-issued
   task automatic load(input logic [2:0] f, input logic [8:0] a, input logic [31:0] exp);
      mem_read = 1'b1; funct3 = f; addr = a;
      q.push_back('{1'b0, exp});
      last_rd = exp;
      @(negedge clk);
      chk("load_stall_req", {31'd0, stall}, 32'd1);
      step();
      @(negedge clk);
      chk("load_stall_wait", {31'd0, stall}, 32'd0);
      step();
      mem_read = 1'b0;
   endtask

   task automatic bad(input logic rd, input logic wr, input logic [2:0] f, input logic [8:0] a);
      mem_read = rd; mem_write = wr; funct3 = f; addr = a; wr_data = 32'hFFFF_FFFF;
      q.push_back('{1'b1, 32'd0});
      @(negedge clk);
      chk("bad_stall", {31'd0, stall}, 32'd0);
      step();
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      chk("bad_rd_hold", rd_data, last_rd);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; funct3 = '0;
      wr_data = '0; last_rd = '0;
      repeat (2) step();
      @(negedge clk);
      chk("reset_rd_data", rd_data, 32'd0);
      chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("reset_err", {31'd0, err}, 32'd0);
      chk("reset_stall", {31'd0, stall}, 32'd0);
      step();
      rst = 1'b0;
      step();
      store(3'b010, 9'h010, 32'hDEAD_BEEF, 1'b0);
      load(3'b010, 9'h010, 32'hDEAD_BEEF);
      store(3'b000, 9'h013, 32'h1234_5680, 1'b0);
      load(3'b000, 9'h013, 32'hFFFF_FF80);
      load(3'b100, 9'h013, 32'h0000_0080);
      load(3'b010, 9'h010, 32'h80AD_BEEF);
      store(3'b010, 9'h020, 32'h1122_3344, 1'b0);
      store(3'b001, 9'h022, 32'hABCD_8001, 1'b0);
      load(3'b001, 9'h022, 32'hFFFF_8001);
      load(3'b101, 9'h022, 32'h0000_8001);
      load(3'b101, 9'h020, 32'h0000_3344);
      load(3'b010, 9'h020, 32'h8001_3344);
      bad(1'b1, 1'b0, 3'b010, 9'h011);
      bad(1'b0, 1'b1, 3'b001, 9'h023);
      load(3'b010, 9'h020, 32'h8001_3344);
      bad(1'b1, 1'b0, 3'b011, 9'h020);
      bad(1'b0, 1'b1, 3'b011, 9'h020);
      bad(1'b1, 1'b0, 3'b001, 9'h021);
      load(3'b010, 9'h020, 32'h8001_3344);
      store(3'b010, 9'h040, 32'h1234_5678, 1'b1);
      load(3'b010, 9'h040, 32'h1234_5678);
      store(3'b000, 9'h041, 32'h0000_005A, 1'b0);
      load(3'b100, 9'h041, 32'h0000_005A);
      load(3'b010, 9'h040, 32'h1234_5A78);
      store(3'b010, 9'h040, 32'hCAFE_F00D, 1'b0);
      load(3'b010, 9'h040, 32'hCAFE_F00D);
      load(3'b000, 9'h040, 32'h0000_000D);
      load(3'b001, 9'h042, 32'hFFFF_CAFE);
      mem_read = 1'b1; funct3 = 3'b010; addr = 9'h010;
      @(negedge clk);
      chk("rstload_stall", {31'd0, stall}, 32'd1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; mem_read = 1'b0;
      @(negedge clk);
      chk("rstload_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rstload_rd_data", rd_data, 32'd0);
      chk("rstload_stall_after", {31'd0, stall}, 32'd0);
      last_rd = '0;
      step();
      load(3'b010, 9'h010, 32'h80AD_BEEF);
      for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
      repeat (3) step();
      chk("queue_drain", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
